simul_axi_wdata_arbiter: RTL
============================

// Module: simul_axi_wdata_arbiter
// PURPOSE
//  Simulation-side arbiter sharing one AXI write-data channel model (wdata FIFO master) between NUM_REQ requesters.
//  Grants whole bursts round-robin, never interleaves beats of different bursts, generates wlast_in,
//  and pushes one beat per cycle into the FIFO via set_cmd whenever the FIFO reports ready.
//  Sits between testbench traffic generators and the write-data channel model.
// PARAMETERS
//  NUM_REQ     2    number of requesters (1..8)
//  ID_WIDTH    12   AXI ID width
//  DATA_WIDTH  32   write data width
//  WSTB_WIDTH  4    write strobe width
//  LEN_WIDTH   4    burst length field width (len = beats-1, AXI3)
// PORTS
//  clk        in   1                    clock, all state changes on posedge
//  reset      in   1                    synchronous, active-high
//  req_valid  in   NUM_REQ              requester i has a burst pending
//  req_id     in   NUM_REQ*ID_WIDTH     burst ID, slice i = requester i
//  req_len    in   NUM_REQ*LEN_WIDTH    beats-1, slice i
//  req_data   in   NUM_REQ*DATA_WIDTH   current beat data, slice i
//  req_strb   in   NUM_REQ*WSTB_WIDTH   current beat strobes, slice i
//  req_grant  out  NUM_REQ              one-hot, held for the whole burst
//  beat_ack   out  NUM_REQ              one-hot pulse: beat of requester i taken this cycle
//  burst_done out  NUM_REQ              one-hot pulse with last beat of requester i
//  wid_in     out  ID_WIDTH             to FIFO model
//  wdata_in   out  DATA_WIDTH           to FIFO model
//  wstrb_in   out  WSTB_WIDTH           to FIFO model
//  wlast_in   out  1                    to FIFO model, high on final beat
//  set_cmd    out  1                    FIFO load strobe
//  ready      in   1                    FIFO can accept an entry
//  busy       out  1                    state != IDLE
// BEHAVIOUR
//  States: IDLE, BURST. Registers: state, gnt_idx, id_r, len_r, beat_cnt (LEN_WIDTH), last_idx (rr pointer).
//  Reset: state=IDLE, req_grant=0, beat_cnt=0, id_r=0, len_r=0, last_idx=NUM_REQ-1 (req 0 wins first);
//   all outputs 0 (set_cmd, beat_ack, burst_done, wlast_in, busy=0). Reset mid-burst aborts it; beats already loaded stay in FIFO.
//  IDLE: if |req_valid, pick first set bit searching last_idx+1, +2, ... (wraps mod NUM_REQ); latch id_r, len_r,
//   gnt_idx; beat_cnt<=0; state<=BURST. req_valid sampled only in IDLE; changes during BURST ignored.
//  BURST: req_grant = onehot(gnt_idx). set_cmd = ready (combinational, no registered path back to ready).
//   wdata_in/wstrb_in = slice gnt_idx of req_data/req_strb (combinational mux); wid_in = id_r.
//   wlast_in = (beat_cnt == len_r). Outside BURST data outputs are 0.
//   beat_ack[gnt_idx] = set_cmd; requester presents next beat the following cycle.
//   On set_cmd & !wlast_in: beat_cnt++. On set_cmd & wlast_in: burst_done[gnt_idx]=1, last_idx<=gnt_idx, state<=IDLE.
//   ready low: hold everything, no ack.
//  Latency: grant 1 cycle after req_valid seen in IDLE; first beat same cycle as grant if ready;
//   burst of L+1 beats with ready always high occupies L+1 cycles; 1 idle cycle between bursts.
//  len_r=0: single beat, wlast_in on first beat. len_r=2^LEN_WIDTH-1: beat_cnt reaches max without wrap.
//  Requester that keeps req_valid high after burst_done is re-arbitrated normally (others get priority first).
// STRUCTURE
//  Shared package: state encoding localparams (ST_IDLE, ST_BURST), onehot/index helper function.
//  Sub-module simul_rr_arbiter (NUM_REQ, req vector + last_idx in -> valid + gnt_idx out), purely combinational.
//  Top holds FSM, counters, latches and output mux.
// TESTING
//  Single req0, len=3, ready=1 -> set_cmd 4 cycles, wlast_in on 4th, burst_done[0] with it, busy low next cycle.
//  req0&req1 both high from reset, len=1 each -> req0 burst (2 beats), 1 idle cycle, req1 burst; no interleave.
//  req1 burst, ready low 3 cycles at beat 2 -> set_cmd/beat_ack low, beat_cnt and data held, resume, total 4 beats.
//  len=0 on req1 with id=12'hABC -> one beat, wid_in=12'hABC, wlast_in=1, burst_done[1].
//  Reset asserted on beat 2 of len=7 burst -> next cycle IDLE, req_grant=0, set_cmd=0; re-grant starts at req0, beat_cnt=0.
//  NUM_REQ=3, all valid continuously, len=0 -> grant order 0,1,2,0,1,2; each burst 1 beat separated by 1 idle cycle.

Source files
------------

// File: rtl/simul_axi_wdata_arbiter_pkg.sv
// Shared types and helpers for the simulation write-data arbiter.
// Requester indices are carried in IDX_W bits, enough for the largest supported NUM_REQ.
package simul_axi_wdata_arbiter_pkg;

  localparam int unsigned MAX_REQ = 8;
  localparam int unsigned IDX_W   = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } state_t;

  // Requester index to one-hot; callers truncate to their NUM_REQ.
  function automatic logic [MAX_REQ-1:0] idx_onehot(input logic [IDX_W-1:0] idx);
    return MAX_REQ'(1) << idx;
  endfunction

endpackage

// File: rtl/simul_rr_arbiter.sv
// Combinational round-robin pick: first set request after last_idx, wrapping mod NUM_REQ.
module simul_rr_arbiter
  import simul_axi_wdata_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   last_idx,
  output logic               valid,
  output logic [IDX_W-1:0]   gnt_idx
);

  always_comb begin
    int unsigned cand;
    cand    = 0;
    valid   = 1'b0;
    gnt_idx = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      cand = 32'(last_idx) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      // Constant select on req keeps the index width exact for any NUM_REQ.
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
        if (!valid && (cand == i) && req[i]) begin
          valid   = 1'b1;
          gnt_idx = IDX_W'(i);
        end
      end
    end
  end

endmodule

// File: rtl/simul_axi_wdata_arbiter.sv
// Shares one AXI write-data FIFO model between NUM_REQ requesters, whole bursts at a time,
// round-robin, one beat per cycle whenever the FIFO reports ready.
module simul_axi_wdata_arbiter
  import simul_axi_wdata_arbiter_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 2,
  parameter int unsigned ID_WIDTH   = 12,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned WSTB_WIDTH = 4,
  parameter int unsigned LEN_WIDTH  = 4
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ*ID_WIDTH-1:0]      req_id,
  input  logic [NUM_REQ*LEN_WIDTH-1:0]     req_len,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]    req_data,
  input  logic [NUM_REQ*WSTB_WIDTH-1:0]    req_strb,
  output logic [NUM_REQ-1:0]               req_grant,
  output logic [NUM_REQ-1:0]               beat_ack,
  output logic [NUM_REQ-1:0]               burst_done,
  output logic [ID_WIDTH-1:0]              wid_in,
  output logic [DATA_WIDTH-1:0]            wdata_in,
  output logic [WSTB_WIDTH-1:0]            wstrb_in,
  output logic                             wlast_in,
  output logic                             set_cmd,
  input  logic                             ready,
  output logic                             busy
);

  state_t                 state, state_nxt;
  logic [IDX_W-1:0]       gnt_idx, gnt_idx_nxt;
  logic [IDX_W-1:0]       last_idx, last_idx_nxt;
  logic [ID_WIDTH-1:0]    id_r, id_nxt;
  logic [LEN_WIDTH-1:0]   len_r, len_nxt;
  logic [LEN_WIDTH-1:0]   beat_cnt, beat_cnt_nxt;

  logic                   arb_valid;
  logic [IDX_W-1:0]       arb_idx;
  logic [ID_WIDTH-1:0]    arb_id;
  logic [LEN_WIDTH-1:0]   arb_len;
  logic [DATA_WIDTH-1:0]  sel_data;
  logic [WSTB_WIDTH-1:0]  sel_strb;
  logic [NUM_REQ-1:0]     gnt_onehot;
  logic                   last_beat;

  simul_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .req      (req_valid),
    .last_idx (last_idx),
    .valid    (arb_valid),
    .gnt_idx  (arb_idx)
  );

  assign gnt_onehot = NUM_REQ'(idx_onehot(gnt_idx));
  assign last_beat  = (beat_cnt == len_r);

  // Burst header of the arbitration winner, latched on entry to BURST.
  always_comb begin
    arb_id  = '0;
    arb_len = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == arb_idx) begin
        arb_id  = req_id[i*ID_WIDTH +: ID_WIDTH];
        arb_len = req_len[i*LEN_WIDTH +: LEN_WIDTH];
      end
    end
  end

  // Live beat of the granted requester; it advances its own slice after each beat_ack.
  always_comb begin
    sel_data = '0;
    sel_strb = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (IDX_W'(i) == gnt_idx) begin
        sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
        sel_strb = req_strb[i*WSTB_WIDTH +: WSTB_WIDTH];
      end
    end
  end

  // Next state and FIFO-side outputs.
  always_comb begin
    state_nxt    = state;
    gnt_idx_nxt  = gnt_idx;
    last_idx_nxt = last_idx;
    id_nxt       = id_r;
    len_nxt      = len_r;
    beat_cnt_nxt = beat_cnt;
    req_grant    = '0;
    beat_ack     = '0;
    burst_done   = '0;
    wid_in       = '0;
    wdata_in     = '0;
    wstrb_in     = '0;
    wlast_in     = 1'b0;
    set_cmd      = 1'b0;
    busy         = 1'b0;

    case (state)
      ST_IDLE: begin
        if (arb_valid) begin
          gnt_idx_nxt  = arb_idx;
          id_nxt       = arb_id;
          len_nxt      = arb_len;
          beat_cnt_nxt = '0;
          state_nxt    = ST_BURST;
        end
      end
      ST_BURST: begin
        busy      = 1'b1;
        req_grant = gnt_onehot;
        set_cmd   = ready;
        wid_in    = id_r;
        wdata_in  = sel_data;
        wstrb_in  = sel_strb;
        wlast_in  = last_beat;
        if (ready) begin
          beat_ack = gnt_onehot;
          if (last_beat) begin
            burst_done   = gnt_onehot;
            last_idx_nxt = gnt_idx;
            state_nxt    = ST_IDLE;
          end else begin
            beat_cnt_nxt = beat_cnt + LEN_WIDTH'(1);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State register; reset points the rr pointer at the last requester so req 0 wins first.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      gnt_idx  <= '0;
      last_idx <= IDX_W'(NUM_REQ - 1);
      id_r     <= '0;
      len_r    <= '0;
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      gnt_idx  <= gnt_idx_nxt;
      last_idx <= last_idx_nxt;
      id_r     <= id_nxt;
      len_r    <= len_nxt;
      beat_cnt <= beat_cnt_nxt;
    end
  end

endmodule
